// File: rtl/wb_byte_master_if.sv
// Command, response and Wishbone signal bundle for wb_byte_master.
// Signal names follow the initiator's point of view (i_ = into the master).
`timescale 1ns/1ps
interface wb_byte_master_if #(
  parameter int DSIZE = 8
);
  logic             i_cmd_vld;
  logic             o_cmd_rdy;
  logic             i_cmd_we;
  logic [DSIZE-1:0] i_cmd_dat;
  logic             o_rsp_vld;
  logic             i_rsp_rdy;
  logic [DSIZE-1:0] o_rsp_dat;
  logic             o_rsp_err;
  logic             o_stb;
  logic             o_we;
  logic [DSIZE-1:0] o_dat;
  logic             i_ack;
  logic [DSIZE-1:0] i_dat;

  modport master (
    input  i_cmd_vld, i_cmd_we, i_cmd_dat, i_rsp_rdy, i_ack, i_dat,
    output o_cmd_rdy, o_rsp_vld, o_rsp_dat, o_rsp_err, o_stb, o_we, o_dat
  );

  modport slave (
    output i_cmd_vld, i_cmd_we, i_cmd_dat, i_rsp_rdy, i_ack, i_dat,
    input  o_cmd_rdy, o_rsp_vld, o_rsp_dat, o_rsp_err, o_stb, o_we, o_dat
  );
endinterface

// File: rtl/wb_byte_master.sv
// Wishbone single-cycle initiator for 8-bit register slaves, one bus cycle per command.
// Define WBM_TIMEOUT_EN to abort a strobe left unacknowledged for TO_CYCLES cycles.
`timescale 1ns/1ps
module wb_byte_master #(
  parameter int DSIZE     = 8,
  parameter int RD_LAT    = 1,
  parameter int TO_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  wb_byte_master_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_RDWAIT = 2'd2,
    S_RSP    = 2'd3
  } state_t;

  localparam logic [1:0]       LAT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
  localparam logic [DSIZE-1:0] ZERO     = {DSIZE{1'b0}};

  if (RD_LAT < 0 || RD_LAT > 3 || TO_CYCLES < 2 || TO_CYCLES > 255) begin : g_bad_param
    $error("wb_byte_master: RD_LAT must be 0..3 and TO_CYCLES 2..255");
  end

  state_t           r_state, w_nxt_state;
  logic             r_stb, w_nxt_stb;
  logic             r_we, w_nxt_we;
  logic [DSIZE-1:0] r_dat, w_nxt_dat;
  logic             r_rsp_vld, w_nxt_rsp_vld;
  logic [DSIZE-1:0] r_rsp_dat, w_nxt_rsp_dat;
  logic             r_rsp_err, w_nxt_rsp_err;
  logic [1:0]       r_lat_cnt, w_nxt_lat_cnt;
`ifdef WBM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  logic [7:0]       r_to_cnt, w_nxt_to_cnt;
`endif

  // State and registered outputs; reset also aborts any cycle in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_dat     <= ZERO;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= ZERO;
      r_rsp_err <= 1'b0;
      r_lat_cnt <= 2'd0;
`ifdef WBM_TIMEOUT_EN
      r_to_cnt  <= 8'd0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_stb     <= w_nxt_stb;
      r_we      <= w_nxt_we;
      r_dat     <= w_nxt_dat;
      r_rsp_vld <= w_nxt_rsp_vld;
      r_rsp_dat <= w_nxt_rsp_dat;
      r_rsp_err <= w_nxt_rsp_err;
      r_lat_cnt <= w_nxt_lat_cnt;
`ifdef WBM_TIMEOUT_EN
      r_to_cnt  <= w_nxt_to_cnt;
`endif
    end
  end

  // Next-state and next-output decode; everything holds unless a branch changes it.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_stb     = r_stb;
    w_nxt_we      = r_we;
    w_nxt_dat     = r_dat;
    w_nxt_rsp_vld = r_rsp_vld;
    w_nxt_rsp_dat = r_rsp_dat;
    w_nxt_rsp_err = r_rsp_err;
    w_nxt_lat_cnt = r_lat_cnt;
`ifdef WBM_TIMEOUT_EN
    w_nxt_to_cnt  = r_to_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.i_cmd_vld) begin
          w_nxt_state = S_REQ;
          w_nxt_stb   = 1'b1;
          w_nxt_we    = bus.i_cmd_we;
          w_nxt_dat   = bus.i_cmd_dat;
`ifdef WBM_TIMEOUT_EN
          w_nxt_to_cnt = 8'd0;
`endif
        end else begin
          w_nxt_state = S_IDLE;
        end
      end
      S_REQ: begin
        // Ack wins over timeout, even in the last counted cycle.
        if (bus.i_ack) begin
          w_nxt_stb     = 1'b0;
          w_nxt_lat_cnt = 2'd0;
          if (r_we) begin
            w_nxt_rsp_vld = 1'b1;
            w_nxt_rsp_dat = ZERO;
            w_nxt_rsp_err = 1'b0;
            w_nxt_state   = S_RSP;
          end else if (RD_LAT == 0) begin
            w_nxt_rsp_vld = 1'b1;
            w_nxt_rsp_dat = bus.i_dat;
            w_nxt_rsp_err = 1'b0;
            w_nxt_state   = S_RSP;
          end else begin
            w_nxt_state = S_RDWAIT;
          end
        end
`ifdef WBM_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          w_nxt_stb     = 1'b0;
          w_nxt_rsp_vld = 1'b1;
          w_nxt_rsp_dat = ZERO;
          w_nxt_rsp_err = 1'b1;
          w_nxt_state   = S_RSP;
        end else begin
          w_nxt_to_cnt = r_to_cnt + 8'd1;
        end
`else
        else begin
          w_nxt_state = S_REQ;
        end
`endif
      end
      S_RDWAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_nxt_rsp_vld = 1'b1;
          w_nxt_rsp_dat = bus.i_dat;
          w_nxt_rsp_err = 1'b0;
          w_nxt_state   = S_RSP;
        end else begin
          w_nxt_lat_cnt = r_lat_cnt + 2'd1;
        end
      end
      S_RSP: begin
        if (bus.i_rsp_rdy) begin
          w_nxt_rsp_vld = 1'b0;
          w_nxt_state   = S_IDLE;
        end else begin
          w_nxt_state = S_RSP;
        end
      end
      default: begin
        w_nxt_state   = S_IDLE;
        w_nxt_stb     = 1'b0;
        w_nxt_rsp_vld = 1'b0;
      end
    endcase
  end

  assign bus.o_cmd_rdy = (r_state == S_IDLE);
  assign bus.o_stb     = r_stb;
  assign bus.o_we      = r_we;
  assign bus.o_dat     = r_dat;
  assign bus.o_rsp_vld = r_rsp_vld;
  assign bus.o_rsp_dat = r_rsp_dat;
`ifdef WBM_TIMEOUT_EN
  assign bus.o_rsp_err = r_rsp_err;
`else
  assign bus.o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_byte_master.sv
// Bench for wb_byte_master: directed stimulus, a transaction-timestamp model checked every cycle,
// and literal expectations from the written scenarios. Honours WBM_TIMEOUT_EN like the design.
`timescale 1ns/1ps
module tb_wb_byte_master;
  localparam int DW  = 8;
  localparam int RDL = 1;
  localparam int TOC = 16;
  localparam int INF = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_byte_master_if #(.DSIZE(DW)) bus ();
  wb_byte_master_if #(.DSIZE(DW)) bus0 ();

  wb_byte_master #(.DSIZE(DW), .RD_LAT(RDL), .TO_CYCLES(TOC)) u_dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  wb_byte_master #(.DSIZE(DW), .RD_LAT(0), .TO_CYCLES(TOC)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) report(name, 32'(act), 32'(exp));
  endtask
  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) report(name, 32'(act), 32'(exp));
  endtask
  task automatic chkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) report(name, act, exp);
  endtask

  // Registered byte slave: one-cycle ack, read data registered on the ack edge.
  logic       slv_ack;
  logic [7:0] slv_rdat;
  logic [7:0] slv_mem = 8'h00;
  bit         slv_hold = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      slv_ack  <= 1'b0;
      slv_rdat <= 8'h00;
    end else begin
      slv_ack <= bus.o_stb & ~slv_ack & ~slv_hold;
      if (bus.o_stb & slv_ack) begin
        if (bus.o_we) slv_mem <= bus.o_dat;
        else          slv_rdat <= slv_mem;
      end
    end
  end
  assign bus.i_ack = slv_ack;
  assign bus.i_dat = slv_rdat;

  // Second slave drives 0x3C combinationally alongside its ack.
  logic slv0_ack;
  always @(posedge clk) begin
    if (rst) slv0_ack <= 1'b0;
    else     slv0_ack <= bus0.o_stb & ~slv0_ack;
  end
  assign bus0.i_ack = slv0_ack;
  assign bus0.i_dat = slv0_ack ? 8'h3C : 8'h00;

  // Model: one transaction described by the cycles where its phases start and end.
  bit         m_valid = 1'b0, m_busy = 1'b0, m_zero = 1'b0, m_rd_pend = 1'b0;
  logic       m_we = 1'b0, m_err = 1'b0;
  logic [7:0] m_dat = 8'h00, m_rdat = 8'h00;
  int         m_stb_on = INF, m_stb_off = INF, m_rsp_on = INF;
  int         cyc = 0;

  task automatic model_check(input int n);
    bit e_stb, e_vld;
    e_stb = m_busy && n >= m_stb_on && n < m_stb_off;
    e_vld = m_busy && n >= m_rsp_on;
    chk1("m_cmd_rdy", bus.o_cmd_rdy, ~m_busy);
    chk1("m_stb", bus.o_stb, e_stb);
    chk1("m_rsp_vld", bus.o_rsp_vld, e_vld);
    if (e_stb) begin
      chk1("m_we", bus.o_we, m_we);
      chk8("m_dat", bus.o_dat, m_dat);
    end
    if (e_vld) begin
      chk8("m_rsp_dat", bus.o_rsp_dat, m_rdat);
      chk1("m_rsp_err", bus.o_rsp_err, m_err);
    end
    if (m_zero) begin
      chk1("m_rst_we", bus.o_we, 1'b0);
      chk8("m_rst_dat", bus.o_dat, 8'h00);
      chk8("m_rst_rsp_dat", bus.o_rsp_dat, 8'h00);
      chk1("m_rst_rsp_err", bus.o_rsp_err, 1'b0);
    end
  endtask

  // Inputs seen now are the ones the design samples at the next edge (cycle n+1 begins there).
  task automatic model_step(input int n);
    int e;
    e = n + 1;
    if (rst === 1'b1) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_zero  = 1'b1;
    end else begin
      m_zero = 1'b0;
      if (m_busy) begin
        if (n >= m_rsp_on && bus.i_rsp_rdy === 1'b1) begin
          m_busy = 1'b0;
        end else if (n >= m_stb_on && n < m_stb_off) begin
          if (bus.i_ack === 1'b1) begin
            m_stb_off = e;
            m_err     = 1'b0;
            if (m_we) begin
              m_rsp_on  = e;
              m_rdat    = 8'h00;
              m_rd_pend = 1'b0;
            end else begin
              m_rsp_on  = e + RDL;
              m_rd_pend = 1'b1;
            end
          end
`ifdef WBM_TIMEOUT_EN
          else if (e - m_stb_on == TOC) begin
            m_stb_off = e;
            m_rsp_on  = e;
            m_err     = 1'b1;
            m_rdat    = 8'h00;
            m_rd_pend = 1'b0;
          end
`endif
        end
        if (m_rd_pend && e == m_rsp_on) begin
          m_rdat    = bus.i_dat;
          m_rd_pend = 1'b0;
        end
      end else if (bus.i_cmd_vld === 1'b1) begin
        m_busy    = 1'b1;
        m_stb_on  = e;
        m_stb_off = INF;
        m_rsp_on  = INF;
        m_we      = bus.i_cmd_we;
        m_dat     = bus.i_cmd_dat;
        m_rd_pend = 1'b0;
        m_err     = 1'b0;
      end
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_valid) model_check(cyc);
      model_step(cyc);
      cyc++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents one command for a single cycle; returns in accept+1.
  task automatic send(input logic we, input logic [7:0] d);
    int k;
    k = 0;
    while (bus.o_cmd_rdy !== 1'b1 && k < 50) begin
      tick;
      k++;
    end
    chk1("cmd_rdy_wait", bus.o_cmd_rdy, 1'b1);
    bus.i_cmd_vld = 1'b1;
    bus.i_cmd_we  = we;
    bus.i_cmd_dat = d;
    tick;
    bus.i_cmd_vld = 1'b0;
  endtask

  initial begin : stimulus
    int cnt;
    bus.i_cmd_vld  = 1'b0;
    bus.i_cmd_we   = 1'b0;
    bus.i_cmd_dat  = 8'h00;
    bus.i_rsp_rdy  = 1'b1;
    bus0.i_cmd_vld = 1'b0;
    bus0.i_cmd_we  = 1'b0;
    bus0.i_cmd_dat = 8'h00;
    bus0.i_rsp_rdy = 1'b1;
    rst = 1'b1;
    repeat (3) tick;
    chk1("rst_stb", bus.o_stb, 1'b0);
    chk1("rst_rsp_vld", bus.o_rsp_vld, 1'b0);
    chk1("rst_cmd_rdy", bus.o_cmd_rdy, 1'b1);
    chk8("rst_dat", bus.o_dat, 8'h00);
    rst = 1'b0;
    tick;

    // Write 0xA5: strobe in accept+1..+2, response in accept+3.
    send(1'b1, 8'hA5);
    chk1("wr_stb_c1", bus.o_stb, 1'b1);
    chk1("wr_we_c1", bus.o_we, 1'b1);
    chk8("wr_dat_c1", bus.o_dat, 8'hA5);
    tick;
    chk1("wr_stb_c2", bus.o_stb, 1'b1);
    tick;
    chk1("wr_stb_c3", bus.o_stb, 1'b0);
    chk1("wr_vld_c3", bus.o_rsp_vld, 1'b1);
    chk8("wr_rdat_c3", bus.o_rsp_dat, 8'h00);
    chk1("wr_err_c3", bus.o_rsp_err, 1'b0);
    tick;
    chk1("wr_vld_c4", bus.o_rsp_vld, 1'b0);
    chk1("wr_rdy_c4", bus.o_cmd_rdy, 1'b1);

    // Read back with RD_LAT=1: response in accept+4.
    send(1'b0, 8'h00);
    chk1("rd_we_c1", bus.o_we, 1'b0);
    tick;
    tick;
    chk1("rd_stb_c3", bus.o_stb, 1'b0);
    chk1("rd_vld_c3", bus.o_rsp_vld, 1'b0);
    tick;
    chk1("rd_vld_c4", bus.o_rsp_vld, 1'b1);
    chk8("rd_dat_c4", bus.o_rsp_dat, 8'hA5);
    chk1("rd_err_c4", bus.o_rsp_err, 1'b0);
    tick;

    // RD_LAT=0 instance: data captured with the ack, response in accept+3.
    bus0.i_cmd_vld = 1'b1;
    bus0.i_cmd_we  = 1'b0;
    tick;
    bus0.i_cmd_vld = 1'b0;
    chk1("rl0_stb_c1", bus0.o_stb, 1'b1);
    tick;
    chk1("rl0_vld_c2", bus0.o_rsp_vld, 1'b0);
    tick;
    chk1("rl0_vld_c3", bus0.o_rsp_vld, 1'b1);
    chk8("rl0_dat_c3", bus0.o_rsp_dat, 8'h3C);
    chk1("rl0_err_c3", bus0.o_rsp_err, 1'b0);
    tick;
    chk1("rl0_vld_c4", bus0.o_rsp_vld, 1'b0);

    // Backpressure on a read response.
    send(1'b1, 8'h5A);
    repeat (3) tick;
    bus.i_rsp_rdy = 1'b0;
    send(1'b0, 8'h00);
    repeat (3) tick;
    for (int i = 0; i < 5; i++) begin
      chk1("bp_vld", bus.o_rsp_vld, 1'b1);
      chk8("bp_dat", bus.o_rsp_dat, 8'h5A);
      chk1("bp_cmd_rdy", bus.o_cmd_rdy, 1'b0);
      tick;
    end
    bus.i_rsp_rdy = 1'b1;
    tick;
    chk1("bp_vld_rel", bus.o_rsp_vld, 1'b0);
    chk1("bp_cmd_rdy_rel", bus.o_cmd_rdy, 1'b1);

    // Slave never acknowledges.
    slv_hold = 1'b1;
    send(1'b0, 8'h00);
    cnt = 0;
`ifdef WBM_TIMEOUT_EN
    while (bus.o_stb === 1'b1 && cnt < 200) begin
      cnt++;
      tick;
    end
    chkn("to_stb_cycles", cnt, 16);
    chk1("to_vld", bus.o_rsp_vld, 1'b1);
    chk1("to_err", bus.o_rsp_err, 1'b1);
    chk8("to_dat", bus.o_rsp_dat, 8'h00);
    slv_hold = 1'b0;
    tick;
`else
    while (bus.o_stb === 1'b1 && cnt < 120) begin
      cnt++;
      tick;
    end
    chkn("noto_stb_hold", cnt, 120);
    slv_hold = 1'b0;
    cnt = 0;
    while (bus.o_rsp_vld !== 1'b1 && cnt < 20) begin
      cnt++;
      tick;
    end
    chk1("noto_rsp_wait", bus.o_rsp_vld, 1'b1);
    chk1("noto_err", bus.o_rsp_err, 1'b0);
    chk8("noto_dat", bus.o_rsp_dat, 8'h5A);
    tick;
`endif

    // Reset on the second strobe cycle aborts the write.
    slv_hold = 1'b1;
    send(1'b1, 8'h77);
    tick;
    chk1("rs_stb_c2", bus.o_stb, 1'b1);
    rst = 1'b1;
    tick;
    chk1("rs_stb_drop", bus.o_stb, 1'b0);
    chk1("rs_vld", bus.o_rsp_vld, 1'b0);
    chk1("rs_cmd_rdy", bus.o_cmd_rdy, 1'b1);
    rst = 1'b0;
    slv_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk1("rs_no_rsp", bus.o_rsp_vld, 1'b0);
    end
    send(1'b1, 8'h11);
    tick;
    tick;
    chk1("rs_wr_vld", bus.o_rsp_vld, 1'b1);
    chk1("rs_wr_err", bus.o_rsp_err, 1'b0);
    tick;
    send(1'b0, 8'h00);
    repeat (3) tick;
    chk1("rs_rd_vld", bus.o_rsp_vld, 1'b1);
    chk8("rs_rd_dat", bus.o_rsp_dat, 8'h11);
    repeat (3) tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
